// File: rtl/alu_issue.sv
// alu_issue: two-stage RV64I decode/issue into an external ALU with a backpressured result register; ALU_ISSUE_BRANCH_EN adds BEQ/BNE resolution
module alu_issue #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      in_opcode,
    input  logic [2:0]      in_funct3,
    input  logic            in_funct7b5,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    output logic [3:0]      alu_op,
    output logic [XLEN-1:0] alu_in1,
    output logic [XLEN-1:0] alu_in2,
    input  logic [XLEN-1:0] alu_out,
    input  logic            alu_zflag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            out_zero,
    output logic            out_branch_taken,
    output logic            out_illegal
);
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    logic            r_d_valid;
    logic [3:0]      r_d_op;
    logic [XLEN-1:0] r_d_a;
    logic [XLEN-1:0] r_d_b;
    logic            r_d_illegal;
    logic            w_e_free;
    logic            w_adv;
    logic            w_acc;
    logic [3:0]      w_op;
    logic            w_ill;
    logic            w_br;
    logic            w_bne;
    assign w_e_free = ~out_valid | out_ready;
    assign in_ready = ~rst & (~r_d_valid | w_e_free);
    assign w_adv    = r_d_valid & w_e_free;
    assign w_acc    = in_valid & in_ready;
    assign alu_op   = r_d_op;
    assign alu_in1  = r_d_a;
    assign alu_in2  = r_d_b;
    // decode instruction fields to an ALU op; anything unrecognised is illegal with op AND
    always_comb begin
        w_op  = OP_AND;
        w_ill = 1'b1;
        w_br  = 1'b0;
        w_bne = 1'b0;
        case (in_opcode)
            7'b0110011: begin
                w_ill = 1'b0;
                case (in_funct3)
                    3'b000:  w_op = in_funct7b5 ? OP_SUB : OP_ADD;
                    3'b111:  w_op = OP_AND;
                    3'b110:  w_op = OP_OR;
                    3'b011:  w_op = OP_SLT;
                    default: w_ill = 1'b1;
                endcase
            end
            7'b0010011: begin
                w_ill = 1'b0;
                case (in_funct3)
                    3'b000:  w_op = OP_ADD;
                    3'b111:  w_op = OP_AND;
                    3'b110:  w_op = OP_OR;
                    3'b011:  w_op = OP_SLT;
                    default: w_ill = 1'b1;
                endcase
            end
            7'b0000011, 7'b0100011: begin
                w_op  = OP_ADD;
                w_ill = 1'b0;
            end
`ifdef ALU_ISSUE_BRANCH_EN
            7'b1100011: begin
                if (in_funct3[2:1] == 2'b00) begin
                    w_op  = OP_SUB;
                    w_ill = 1'b0;
                    w_br  = 1'b1;
                    w_bne = in_funct3[0];
                end
            end
`endif
            default: w_ill = 1'b1;
        endcase
        if (w_ill) w_op = OP_AND;
    end
    // stage D: valid flag follows accept/advance, payload loads only on accept so ALU inputs stay stable when idle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_d_valid   <= 1'b0;
            r_d_op      <= OP_AND;
            r_d_a       <= '0;
            r_d_b       <= '0;
            r_d_illegal <= 1'b0;
        end else begin
            if (w_acc) r_d_valid <= 1'b1;
            else if (w_adv) r_d_valid <= 1'b0;
            if (w_acc) begin
                r_d_op      <= w_op;
                r_d_a       <= in_a;
                r_d_b       <= in_b;
                r_d_illegal <= w_ill;
            end
        end
    end
    // stage E: capture the ALU result when D advances, illegal ops are forced to a zero result
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_zero    <= 1'b0;
            out_illegal <= 1'b0;
        end else begin
            if (w_adv) out_valid <= 1'b1;
            else if (out_ready) out_valid <= 1'b0;
            if (w_adv) begin
                out_result  <= r_d_illegal ? '0 : alu_out;
                out_zero    <= ~r_d_illegal & alu_zflag;
                out_illegal <= r_d_illegal;
            end
        end
    end
`ifdef ALU_ISSUE_BRANCH_EN
    logic r_d_br;
    logic r_d_bne;
    logic r_taken;
    assign w_unused_br = 1'b0;
    assign out_branch_taken = r_taken;
    // branch decode bits travel with the op through D
    always_ff @(posedge clk) begin
        if (rst) begin
            r_d_br  <= 1'b0;
            r_d_bne <= 1'b0;
        end else if (w_acc) begin
            r_d_br  <= w_br;
            r_d_bne <= w_bne;
        end
    end
    // branch outcome resolved from the ALU zero flag of the SUB
    always_ff @(posedge clk) begin
        if (rst) r_taken <= 1'b0;
        else if (w_adv) r_taken <= r_d_br & ~r_d_illegal & (r_d_bne ? ~alu_zflag : alu_zflag);
    end
`else
    logic w_unused_br;
    assign w_unused_br = w_br | w_bne;
    assign out_branch_taken = 1'b0;
`endif
endmodule

// File: doc/alu_issue.md
# alu_issue

Two-stage pipelined issue/decode block that drives the combinational 64-bit `ALU` and captures its result. It accepts RV64I instruction fields plus operands over a valid/ready handshake, decodes them to the ALU's 4-bit `ALUop`, presents operands to the ALU, and registers `out`/`zflag` into a backpressured result stage. It sits between register-read and writeback/branch logic in the datapath.

## Interface
- `XLEN`, default 64: operand and result width. Must match the ALU width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  upstream presents an operation.
- `in_ready`  out  1  block accepts the operation this cycle.
- `in_opcode`  in  7  instruction bits [6:0].
- `in_funct3`  in  3  instruction bits [14:12].
- `in_funct7b5`  in  1  instruction bit 30.
- `in_a`  in  XLEN  operand A (rs1 value).
- `in_b`  in  XLEN  operand B (rs2 value or sign-extended immediate, chosen upstream).
- `alu_op`  out  4  to ALU `ALUop`.
- `alu_in1`, `alu_in2`  out  XLEN  to ALU `in1`/`in2`.
- `alu_out`  in  XLEN  from ALU `out`.
- `alu_zflag`  in  1  from ALU `zflag`.
- `out_valid`  out  1  result register holds a result.
- `out_ready`  in  1  downstream consumes the result.
- `out_result`  out  XLEN  registered ALU result; 0 for illegal ops.
- `out_zero`  out  1  registered zero flag.
- `out_branch_taken`  out  1  branch resolved taken.
- `out_illegal`  out  1  operation not decodable to a supported ALUop.

## Operation
- Decode, registered into stage D on acceptance:
  - opcode 0110011: funct3 000/b5=0 → 0010 ADD; 000/b5=1 → 0110 SUB; 111 → 0000 AND; 110 → 0001 OR; 011 → 0111 SLT (unsigned compare, SLTU).
  - opcode 0010011: funct3 000 → ADD; 111 → AND; 110 → OR; 011 → SLT (SLTIU). `in_funct7b5` is ignored.
  - opcode 0000011 and 0100011 (load/store address): ADD.
  - opcode 1100011: see Configuration.
  - All other encodings, including signed SLT (funct3 010), are illegal. ALUop 1100 (NOR) is never issued.
- Stage D is a register set: `d_valid`, `d_op`, `d_a`, `d_b`, `d_illegal`, `d_br`, `d_bne`. The outputs `alu_op`, `alu_in1`, and `alu_in2` are driven directly from the D registers.
- Stage E is the result register set. When stage D advances, the E registers capture:
  - `out_result` = `d_illegal` ? 0 : `alu_out`
  - `out_zero` = `d_illegal` ? 0 : `alu_zflag`
  - `out_branch_taken` = `d_br` & ~`d_illegal` & (`d_bne` ? ~`alu_zflag` : `alu_zflag`)
  - `out_illegal` = `d_illegal`
- For an illegal op, `d_op` = 0000 and operands are still registered. The ALU output is then don't-care.
- Handshake:
  - `e_free` = ~`out_valid` | `out_ready`
  - `in_ready` = ~`rst` & (~`d_valid` | `e_free`)
  - Stage D advances when `d_valid` & `e_free`.
  - `out_valid` is set on advance. It clears when `out_ready` is high and no advance happens in the same cycle.
- When stage D is empty, the D registers hold their last values, so the ALU inputs stay stable.
- Downstream stall: `out_valid` & ~`out_ready` holds E, then D; `in_ready` drops once D is full. No data is lost or duplicated.
- Simultaneous accept and advance in one cycle is legal: D reloads while E loads the old D contents.
- Reset:
  - All registers clear, and `d_valid` and `out_valid` go to 0.
  - `alu_op` resets to 0000; `alu_in1`, `alu_in2`, and all `out_*` data outputs reset to 0.
  - `in_ready` is 0 while `rst` is high.
  - Reset mid-operation discards in-flight operations without producing a result.

## Timing
- Latency: accepted at edge N; ALU driven in cycle N+1; `out_valid` from edge N+1, held until `out_ready`.
- Throughput: one operation per cycle with `out_ready` held high.
- The ALU combinational path (D registers → ALU → E registers) is the critical path and must close in one cycle.
- `in_ready` depends combinationally on `out_ready`, so there is one combinational handshake path.

## Configuration
- `ALU_ISSUE_BRANCH_EN`
  - Defined: opcode 1100011 with funct3 000 (BEQ) or 001 (BNE) decodes to SUB, sets `d_br`, and sets `d_bne` = funct3[0]. Other branch funct3 values are illegal.
  - Undefined: all opcode 1100011 encodings are illegal, and `out_branch_taken` is constant 0.

## Test plan
- ADD, a=5, b=7, `out_ready`=1 → two cycles later `out_result`=12, `out_zero`=0, `out_illegal`=0, `alu_op` observed as 0010.
- SUB (b5=1), a=b=0x1234 → `out_result`=0, `out_zero`=1; then SLTU a=3, b=0xFFFF_FFFF_FFFF_FFFF → `out_result`=1.
- Back-to-back stream AND, OR, ADD with `out_ready` low for 3 cycles mid-stream → `in_ready` drops after D fills; results appear in order (0x0F&0xFF=0x0F, 0xF0|0x0F=0xFF, 1+1=2) with none lost or duplicated.
- Signed SLT (opcode 0110011, funct3 010) and opcode 0110111 → `out_illegal`=1, `out_result`=0, `alu_op`=0000.
- With `ALU_ISSUE_BRANCH_EN` defined: BEQ a=b=9 → `out_branch_taken`=1; BNE a=9, b=9 → 0. With it undefined: BEQ → `out_illegal`=1, taken=0.
- Assert `rst` for 1 cycle while D and E are both valid → next cycle `out_valid`=0, `alu_op`=0000, no result emitted; the next accepted ADD 2+2 yields 4.
